mem_stage_unit: RTL
===================

Name: mem_stage_unit

Overview:
- Memory-access stage of the 5-stage RV32 pipeline. Sits between the EX/MEM pipeline register and the write-back stage.
- Consumes the EX/MEM register outputs and resolves branches (pc_src).
- Runs a load/store handshake with a variable-latency data memory, stalling upstream while the access is in progress.
- Contains the MEM/WB pipeline register, including bubble insertion, misaligned-access detection and a bus timeout.

Parameters:
- TIMEOUT, 16: maximum number of request cycles before an access is aborted; legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- branch_target_in  in  32  branch target from EX/MEM
- alu_result_in  in  32  effective address or ALU result
- store_data_in  in  32  store data (rs2)
- rd_in  in  5  destination register
- wb_reg_write_in  in  1  WB control
- wb_mem_to_reg_in  in  1  WB control
- m_branch_in  in  1  branch instruction
- m_mem_read_in  in  1  load
- m_mem_write_in  in  1  store
- alu_zero_in  in  1  ALU zero flag
- dmem_req  out  1  memory request (combinational)
- dmem_we  out  1  1 = write
- dmem_addr  out  32  equals alu_result_in
- dmem_wdata  out  32  equals store_data_in
- dmem_ready  in  1  access completes in the cycle it is high
- dmem_rdata  in  32  valid while dmem_ready is high (loads)
- pc_src  out  1  m_branch_in & alu_zero_in (combinational)
- branch_target_out  out  32  passthrough of branch_target_in
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- mem_read_data_out  out  32  MEM/WB register: load data
- alu_result_out  out  32  MEM/WB register
- rd_out  out  5  MEM/WB register
- wb_reg_write_out  out  1  MEM/WB register
- wb_mem_to_reg_out  out  1  MEM/WB register
- misaligned_out  out  1  registered 1-cycle pulse
- bus_error_out  out  1  registered 1-cycle pulse

Behaviour:
- Reset (async): state=IDLE, wait_cnt=0, all registered outputs 0. While reset is high, dmem_req=0 and stall=0.
- memop = m_mem_read_in | m_mem_write_in. If both are high, it is treated as a read. dmem_we = m_mem_write_in & ~m_mem_read_in.
- misalign = memop & (alu_result_in[1:0] != 0). Only word accesses are supported.
- dmem_req = memop & ~misalign & state-not-aborting.
- FSM states: IDLE and WAIT. wait_cnt is 8 bits and counts completed request cycles without dmem_ready.
- IDLE, no memop or misalign: stall=0; MEM/WB captures this cycle.
- IDLE, request with dmem_ready=1: zero-wait access. stall=0; MEM/WB captures; stay in IDLE.
- IDLE, request with dmem_ready=0: stall=1; go to WAIT; wait_cnt=1.
- WAIT with dmem_ready=1: stall=0; MEM/WB captures; go to IDLE; wait_cnt=0.
- WAIT with dmem_ready=0 and wait_cnt<TIMEOUT: stall=1; wait_cnt+1.
- WAIT with wait_cnt==TIMEOUT (abort cycle): dmem_req=0 and stall=0. At the edge: bus_error_out<=1, MEM/WB gets a bubble, go to IDLE, wait_cnt=0. dmem_req is therefore high for exactly TIMEOUT cycles.
- MEM/WB capture (edge with stall=0, no abort, no misalign):
  - alu_result_out, rd_out, wb_reg_write_out and wb_mem_to_reg_out take the inputs.
  - mem_read_data_out <= dmem_rdata for a completing load, else 0.
- Bubble (edge with stall=1, abort, or misalign): wb_reg_write_out<=0, wb_mem_to_reg_out<=0, rd_out<=0, data outputs<=0.
- misaligned_out / bus_error_out: high for exactly one cycle after the triggering edge, else 0.
- Latency: a non-memory instruction is visible on the MEM/WB outputs 1 cycle after it appears on the inputs. A memory instruction appears 1 cycle after the dmem_ready cycle.
- pc_src is independent of stall. The consumer uses it only when stall=0.
- Upstream holds all *_in inputs stable while stall=1.
- Reset asserted mid-WAIT: immediate return to IDLE, dmem_req drops asynchronously, no bus_error pulse.

Test Plan:
- ALU op: alu_result_in=0x1234, rd_in=5, wb_reg_write_in=1, no memop -> next cycle alu_result_out=0x1234, rd_out=5, wb_reg_write_out=1, stall never high.
- Load with 3-cycle latency: alu_result_in=0x100, m_mem_read_in=1, dmem_ready high on the 3rd request cycle with dmem_rdata=0xDEADBEEF -> stall high for 2 cycles, dmem_req high for 3, 2 bubbles (wb_reg_write_out=0), then mem_read_data_out=0xDEADBEEF with wb_mem_to_reg_out=1.
- Zero-wait store: m_mem_write_in=1, addr 0x20, data 0x55, dmem_ready=1 in the same cycle -> dmem_we=1, dmem_wdata=0x55, stall=0, dmem_req high 1 cycle.
- Misaligned load: addr 0x102 -> dmem_req=0, stall=0, misaligned_out pulses 1 cycle, wb_reg_write_out=0.
- Timeout with TIMEOUT=4 and dmem_ready held 0 -> dmem_req high 4 cycles, stall high 4 cycles, abort cycle stall=0, bus_error_out pulses once, writeback squashed.
- Branch plus reset: m_branch_in=1, alu_zero_in=1, target 0x40 -> pc_src=1, branch_target_out=0x40 in the same cycle. Reset asserted in WAIT -> dmem_req/stall=0 immediately, all outputs 0, no error pulse.

Source files
------------

// File: rtl/mem_stage_unit.sv
// Memory-access stage of the RV32 pipeline: branch resolution, a data-memory handshake with
// stall and bus timeout, misaligned-access detection and the MEM/WB pipeline register.
module mem_stage_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] branch_target_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        wb_reg_write_in,
  input  logic        wb_mem_to_reg_in,
  input  logic        m_branch_in,
  input  logic        m_mem_read_in,
  input  logic        m_mem_write_in,
  input  logic        alu_zero_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        pc_src,
  output logic [31:0] branch_target_out,
  output logic        stall,
  output logic [31:0] mem_read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        wb_reg_write_out,
  output logic        wb_mem_to_reg_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_r, state_nxt_s;
  logic [7:0] wait_cnt_r, wait_cnt_nxt_s;
  logic       memop_s, misalign_s, abort_s, req_s, stall_s, capture_s, load_done_s;

  // State register and wait-cycle counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Next-state logic; a vanished request in WAIT falls back to IDLE defensively.
  always_comb begin
    state_nxt_s    = ST_IDLE;
    wait_cnt_nxt_s = 8'd0;
    case (state_r)
      ST_IDLE: begin
        if (stall_s) begin
          state_nxt_s    = ST_WAIT;
          wait_cnt_nxt_s = 8'd1;
        end else begin
          state_nxt_s    = ST_IDLE;
          wait_cnt_nxt_s = 8'd0;
        end
      end
      ST_WAIT: begin
        if (abort_s || !req_s || dmem_ready) begin
          state_nxt_s    = ST_IDLE;
          wait_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s    = ST_WAIT;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        wait_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Handshake outputs; request and stall are forced low while reset is held.
  always_comb begin
    memop_s     = m_mem_read_in | m_mem_write_in;
    misalign_s  = memop_s & (alu_result_in[1:0] != 2'b00);
    abort_s     = (state_r == ST_WAIT) && (wait_cnt_r == TIMEOUT_C);
    req_s       = memop_s & ~misalign_s & ~abort_s & ~reset;
    stall_s     = req_s & ~dmem_ready;
    capture_s   = ~stall_s & ~abort_s & ~misalign_s;
    load_done_s = req_s & dmem_ready & m_mem_read_in;
  end

  assign dmem_req          = req_s;
  assign stall             = stall_s;
  assign dmem_we           = m_mem_write_in & ~m_mem_read_in;
  assign dmem_addr         = alu_result_in;
  assign dmem_wdata        = store_data_in;
  assign pc_src            = m_branch_in & alu_zero_in;
  assign branch_target_out = branch_target_in;

  // MEM/WB register: capture on a completed cycle, bubble on stall, abort or misalign.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_read_data_out <= 32'd0;
      alu_result_out    <= 32'd0;
      rd_out            <= 5'd0;
      wb_reg_write_out  <= 1'b0;
      wb_mem_to_reg_out <= 1'b0;
      misaligned_out    <= 1'b0;
      bus_error_out     <= 1'b0;
    end else begin
      misaligned_out <= misalign_s;
      bus_error_out  <= abort_s;
      if (capture_s) begin
        mem_read_data_out <= load_done_s ? dmem_rdata : 32'd0;
        alu_result_out    <= alu_result_in;
        rd_out            <= rd_in;
        wb_reg_write_out  <= wb_reg_write_in;
        wb_mem_to_reg_out <= wb_mem_to_reg_in;
      end else begin
        mem_read_data_out <= 32'd0;
        alu_result_out    <= 32'd0;
        rd_out            <= 5'd0;
        wb_reg_write_out  <= 1'b0;
        wb_mem_to_reg_out <= 1'b0;
      end
    end
  end

endmodule
